// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable rx/tx baud-enable generator.
//
// Produces a one-cycle rx_tick every L clk cycles (L = clamped divisor,
// plus one when the fractional carry is set) and a tx_tick on every
// OVERSAMPLE-th rx_tick. Build option: define BAUD_FRAC_EN to include the
// fractional accumulator; without it L is the integer divisor only and
// div_frac is ignored (the port list is the same in both builds).
//
// Strobe semantics: div_load and tx_resync are single-cycle strobes sampled
// on the rising clk edge, with no back-pressure. rx_tick and tx_tick are
// single-cycle clock enables decoded from registered state, so they are high
// on the cycle the rx counter sits at L-1 while enable is high.
module baud_gen_frac #(
    parameter int CLK_FREQ     = 50000000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_BITS    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    input  logic                 div_load,
    input  logic                 tx_resync,
    output logic                 rx_tick,
    output logic                 tx_tick,
    output logic                 load_pending
);

    localparam int BAUD_X = DEFAULT_BAUD * OVERSAMPLE;
    localparam logic [DIV_WIDTH-1:0] DEFAULT_INT = DIV_WIDTH'(CLK_FREQ / BAUD_X);
    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] div_act;
    logic [DIV_WIDTH-1:0] div_pend;
    logic                 load_armed;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [PH_W-1:0]      phase;
    logic                 carry_flag;

    logic [DIV_WIDTH-1:0] d_eff;
    logic [DIV_WIDTH:0]   last_cnt;
    logic                 rx_wrap;
    logic                 phase_last;
    logic                 apply;

    // Divisors below 2 cannot produce a distinct tick cycle, so clamp to 2.
    assign d_eff      = (div_act < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_act;
    assign last_cnt   = {1'b0, d_eff} - (DIV_WIDTH + 1)'(1)
                        + {{DIV_WIDTH{1'b0}}, carry_flag};
    assign rx_wrap    = enable && ({1'b0, rx_cnt} == last_cnt);
    assign phase_last = (phase == PH_LAST);

    // A pending divisor takes effect on resync, or at the end of the first
    // full rx period after capture (a fresh load on that cycle defers it).
    assign apply = load_pending &&
                   (tx_resync || (rx_wrap && load_armed && !div_load));

    assign rx_tick = rx_wrap;
    assign tx_tick = rx_wrap && phase_last && !tx_resync;

    // Divisor capture, arming and application.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_act      <= DEFAULT_INT;
            div_pend     <= DEFAULT_INT;
            load_pending <= 1'b0;
            load_armed   <= 1'b0;
        end else begin
            if (apply) begin
                div_act      <= div_pend;
                load_pending <= 1'b0;
                load_armed   <= 1'b0;
            end else if (rx_wrap && load_pending) begin
                // The period that just ended began after capture; the next
                // one is the first full period, so arm for its end.
                load_armed <= 1'b1;
            end
            if (div_load) begin
                div_pend     <= div_int;
                load_pending <= 1'b1;
                // Capturing on a wrap or resync means the next period is
                // already a full one.
                load_armed   <= rx_wrap || tx_resync;
            end
        end
    end

    // Rx period counter and tx phase counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_cnt <= '0;
            phase  <= '0;
        end else if (tx_resync) begin
            rx_cnt <= '0;
            phase  <= '0;
        end else if (rx_wrap) begin
            rx_cnt <= '0;
            phase  <= phase_last ? '0 : phase + PH_W'(1);
        end else if (enable) begin
            rx_cnt <= rx_cnt + DIV_WIDTH'(1);
        end
    end

`ifdef BAUD_FRAC_EN
    localparam logic [FRAC_BITS-1:0] DEFAULT_FRAC =
        FRAC_BITS'(((CLK_FREQ % BAUD_X) * (2 ** FRAC_BITS)) / BAUD_X);

    logic [FRAC_BITS-1:0] frac_act;
    logic [FRAC_BITS-1:0] frac_pend;
    logic [FRAC_BITS-1:0] acc;

    // Fractional divisor registers and the accumulator whose carry stretches
    // the following rx period by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frac_act   <= DEFAULT_FRAC;
            frac_pend  <= DEFAULT_FRAC;
            acc        <= '0;
            carry_flag <= 1'b0;
        end else begin
            if (div_load) begin
                frac_pend <= div_frac;
            end
            if (apply) begin
                frac_act <= frac_pend;
            end
            if (tx_resync || apply) begin
                acc        <= '0;
                carry_flag <= 1'b0;
            end else if (rx_wrap) begin
                {carry_flag, acc} <= {1'b0, acc} + {1'b0, frac_act};
            end
        end
    end
`else
    logic unused_div_frac;

    // Integer-only build: every rx period is exactly the clamped divisor.
    assign carry_flag      = 1'b0;
    assign unused_div_frac = ^div_frac;
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios push expected rx/tx tick cycle
// numbers into queues; a negedge monitor pops and compares on every tick.
module tb_baud_gen_frac;

    localparam int OS = 16;
    // Default divisor at 50 MHz / (9600*16): 325 integer, fraction 8/16.
`ifdef BAUD_FRAC_EN
    localparam int FSTEP = 8;
`else
    localparam int FSTEP = 0;
`endif

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        tx_resync;
    logic        rx_tick;
    logic        tx_tick;
    logic        load_pending;

    logic [31:0] exp_rx_q[$];
    logic [31:0] exp_tx_q[$];
    int          cyc;
    int          n_cmp;
    int          n_err;
    bit          mon_on;

    baud_gen_frac dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .div_int      (div_int),
        .div_frac     (div_frac),
        .div_load     (div_load),
        .tx_resync    (tx_resync),
        .rx_tick      (rx_tick),
        .tx_tick      (tx_tick),
        .load_pending (load_pending)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #10 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(20 * 100000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        n_err++;
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Advance to just after the rising edge that starts cycle c.
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_lp(input int c, input bit expv);
        wait_cyc(c);
        @(negedge clk);
        check("load_pending", load_pending, expv);
    endtask

    // Push n expected rx ticks (and tx ticks on the last phase) from t0.
    task automatic push_run(input int t0, input int ph0, input int n, input int d,
                            input int step, output int t_last, output int t_next);
        int t, ph, acc, c;
        t = t0; ph = ph0; acc = 0; t_last = t0;
        for (int i = 0; i < n; i++) begin
            exp_rx_q.push_back(t);
            if (ph == OS - 1) exp_tx_q.push_back(t);
            t_last = t;
            ph  = (ph + 1) % OS;
            acc = acc + step;
            c   = (acc >= 16) ? 1 : 0;
            acc = acc % 16;
            t   = t + d + c;
        end
        t_next = t;
    endtask

    task automatic end_check();
        check("rx ticks still expected", exp_rx_q.size(), 0);
        check("tx ticks still expected", exp_tx_q.size(), 0);
        exp_rx_q.delete();
        exp_tx_q.delete();
    endtask

    task automatic do_reset(output int r);
        mon_on = 1'b0;
        end_check();
        rstn = 1'b0; enable = 1'b0; div_load = 1'b0; tx_resync = 1'b0;
        div_int = '0; div_frac = '0;
        @(negedge clk);
        check("reset rx_tick", rx_tick, 0);
        check("reset tx_tick", tx_tick, 0);
        check("reset load_pending", load_pending, 0);
        wait_cyc(cyc + 4);
        rstn = 1'b1; enable = 1'b1; mon_on = 1'b1;
        r = cyc;
    endtask

    // Monitor: every tick must match the head of its expected queue.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rx_tick) begin
                if (exp_rx_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rx_tick: unexpected pulse at cycle %0d, none expected", cyc);
                end else begin
                    check("rx_tick cycle", cyc, int'(exp_rx_q.pop_front()));
                end
            end
            if (tx_tick) begin
                if (exp_tx_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL tx_tick: unexpected pulse at cycle %0d, none expected", cyc);
                end else begin
                    check("tx_tick cycle", cyc, int'(exp_tx_q.pop_front()));
                end
                if (!rx_tick) begin
                    n_cmp++; n_err++;
                    $display("FAIL tx_without_rx: tx_tick=1 rx_tick=0 at cycle %0d, required rx_tick=1", cyc);
                end
            end
        end
    end

    initial begin
        int r, s, s2, t, tl, tn;
        n_cmp = 0; n_err = 0; mon_on = 1'b0;
        rstn = 1'b0; enable = 1'b0; div_int = '0; div_frac = '0;
        div_load = 1'b0; tx_resync = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Default divisor free-running.
        do_reset(r);
        push_run(r + 324, 0, 33, 325, FSTEP, tl, tn);
        wait_cyc(tl + 1);

        // Mid-period load of divisor 27: applies at the second period end.
        do_reset(r);
        push_run(r + 324, 0, 2, 325, FSTEP, tl, tn);
        push_run(r + 676, 2, 31, 27, 0, tl, tn);
        wait_cyc(r + 100);
        div_int = 16'd27; div_frac = 4'd0; div_load = 1'b1;
        @(negedge clk);
        check("load_pending before capture", load_pending, 0);
        wait_cyc(r + 101);
        div_load = 1'b0;
        check_lp(r + 101, 1'b1);
        check_lp(r + 649, 1'b1);
        check_lp(r + 650, 1'b0);
        wait_cyc(tl + 1);

        // Resync at an arbitrary phase, then again on a would-be tx tick.
        do_reset(r);
        push_run(r + 324, 0, 3, 325, FSTEP, tl, tn);
        s = r + 1000;
        wait_cyc(s);
        tx_resync = 1'b1;
        wait_cyc(s + 1);
        tx_resync = 1'b0;
        push_run(s + 325, 0, 15, 325, FSTEP, tl, s2);
        exp_rx_q.push_back(s2);
        wait_cyc(s2);
        tx_resync = 1'b1;
        @(negedge clk);
        check("tx_tick on resync cycle", tx_tick, 0);
        wait_cyc(s2 + 1);
        tx_resync = 1'b0;
        push_run(s2 + 325, 0, 17, 325, FSTEP, tl, tn);
        wait_cyc(tl + 1);

        // Divisors 0 and 1 clamp to 2; second load lands on a tick cycle.
        do_reset(r);
        push_run(r + 324, 0, 2, 325, FSTEP, tl, tn);
        push_run(r + 651, 2, 40, 2, 0, tl, tn);
        wait_cyc(r + 10);
        div_int = 16'd0; div_frac = 4'd0; div_load = 1'b1;
        wait_cyc(r + 11);
        div_load = 1'b0;
        t = r + 689;
        wait_cyc(t);
        div_int = 16'd1; div_load = 1'b1;
        @(negedge clk);
        check("load_pending on tick-cycle load", load_pending, 0);
        wait_cyc(t + 1);
        div_load = 1'b0;
        check_lp(t + 1, 1'b1);
        check_lp(t + 2, 1'b1);
        check_lp(t + 3, 1'b0);
        wait_cyc(tl + 1);

        // Enable gap of 100 cycles, load while frozen, then reset mid-pending.
        do_reset(r);
        push_run(r + 424, 0, 1, 325, FSTEP, tl, tn);
        wait_cyc(r + 100);
        enable = 1'b0;
        wait_cyc(r + 150);
        div_int = 16'd27; div_load = 1'b1;
        wait_cyc(r + 151);
        div_load = 1'b0;
        check_lp(r + 151, 1'b1);
        wait_cyc(r + 200);
        enable = 1'b1;
        wait_cyc(r + 500);
        do_reset(r);
        push_run(r + 324, 0, 3, 325, FSTEP, tl, tn);
        wait_cyc(tl + 1);

        mon_on = 1'b0;
        end_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
